dnn_block_feeder: RTL and testbench

// Block-cycle sequencer and stream front-end for the DNN. Counts CPC clocks per training case and

---
 rtl/dnn_block_feeder.sv | 105 ++++++++++
 tb/tb_dnn_block_feeder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dnn_block_feeder.sv
// dnn_block_feeder
// Block-cycle sequencer and stream front-end for the DNN.
// A block is CPC clocks long and corresponds to one training case. Within a
// block the full activation vector and the full ideal-output vector are fed
// to the DNN one slice per clock. The DNN's thresholded output is compared
// with its delayed ideal output, and per-case and total error counts are kept.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   a           full activation vector, neuron k at [k*WIDTH_IN +: WIDTH_IN]
//   y           full ideal-output vector of the current case
//   a_out       DNN thresholded actual output
//   y_out       DNN delayed ideal output
//   a_in        activation chunk for the current slice
//   y_in        ideal-output chunk for the current slice
//   count       cycle index within the block, 0..CPC-1
//   sel         slice select
//   cycle_clk   one-clock pulse following each block boundary
//   tc_error    error flag of the last completed case
//   total_error number of completed cases that had an error
//   num_cases   number of completed cases
module dnn_block_feeder #(
  parameter int WIDTH_IN    = 8,
  parameter int N_IN        = 1024,
  parameter int ACT_PER_CLK = 64,
  parameter int N_OUT       = 16,
  parameter int OUT_PER_CLK = 1,
  parameter int CPC         = 18,
  localparam int NS         = CPC - 2,
  localparam int SW         = $clog2(NS),
  localparam int CW         = $clog2(CPC)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WIDTH_IN*N_IN-1:0]        a,
  input  logic [N_OUT-1:0]                y,
  input  logic [OUT_PER_CLK-1:0]          a_out,
  input  logic [OUT_PER_CLK-1:0]          y_out,
  output logic [WIDTH_IN*ACT_PER_CLK-1:0] a_in,
  output logic [OUT_PER_CLK-1:0]          y_in,
  output logic [CW-1:0]                   count,
  output logic [SW-1:0]                   sel,
  output logic                            cycle_clk,
  output logic                            tc_error,
  output logic [31:0]                     total_error,
  output logic [31:0]                     num_cases
);

  localparam int CHUNK = WIDTH_IN * ACT_PER_CLK;

  logic [CW-1:0] count_m2;
  logic          wrap;
  logic          mismatch;
  logic          err_acc;
  logic          case_err;

  assign wrap     = (count == CW'(CPC - 1));
  assign mismatch = (a_out != y_out);
  assign case_err = err_acc | mismatch;

  // The DNN pipeline is two clocks deep, so slice 0 is presented at count 2
  // and the last two slices wrap around into counts 0 and 1.
  assign count_m2 = count - CW'(2);
  assign sel      = count_m2[SW-1:0];

  always_comb begin
    a_in = '0;
    y_in = '0;
    if ({1'b0, sel} < (SW + 1)'(NS)) begin
      a_in = a[int'(sel) * CHUNK +: CHUNK];
      y_in = y[int'(sel) * OUT_PER_CLK +: OUT_PER_CLK];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      cycle_clk <= 1'b0;
    end else begin
      count     <= wrap ? '0 : count + CW'(1);
      cycle_clk <= wrap;
    end
  end

  // Counts 0 and 1 still carry the previous case's pipeline tail, so they are
  // not compared. On the wrap edge the current cycle's mismatch is folded in
  // directly, so it is neither lost nor carried into the next case.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_acc     <= 1'b0;
      tc_error    <= 1'b0;
      total_error <= '0;
      num_cases   <= '0;
    end else if (wrap) begin
      tc_error    <= case_err;
      total_error <= total_error + 32'(case_err);
      num_cases   <= num_cases + 32'd1;
      err_acc     <= 1'b0;
    end else if (count >= CW'(2) && mismatch) begin
      err_acc <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dnn_block_feeder.sv
// Testbench for dnn_block_feeder: per-cycle checks of count, cycle_clk and
// slice outputs, plus a scoreboard of per-case results popped on cycle_clk.
module tb_dnn_block_feeder;

  logic             clk = 1'b0;
  logic             reset;
  logic [8191:0]    a;
  logic [15:0]      y;
  logic [0:0]       a_out, y_out;
  logic [511:0]     a_in;
  logic [0:0]       y_in;
  logic [4:0]       count;
  logic [3:0]       sel;
  logic             cycle_clk;
  logic             tc_error;
  logic [31:0]      total_error;
  logic [31:0]      num_cases;

  dnn_block_feeder dut (
    .clk(clk), .reset(reset), .a(a), .y(y), .a_out(a_out), .y_out(y_out),
    .a_in(a_in), .y_in(y_in), .count(count), .sel(sel), .cycle_clk(cycle_clk),
    .tc_error(tc_error), .total_error(total_error), .num_cases(num_cases)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit tc;
    int tot;
    int num;
  } res_t;
  res_t q[$];

  int mcount, mtot, mnum;
  bit macc;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_slices();
    int es;
    logic [511:0] ea;
    es = (mcount < 2) ? mcount + 14 : mcount - 2;
    for (int j = 0; j < 64; j++) ea[j*8 +: 8] = 8'(es * 64 + j);
    chk("sel", sel, es);
    chk("a_in", a_in, ea);
    chk("y_in", y_in, y[es]);
  endtask

  // One clock with a mismatch (or not) presented across the coming edge.
  task automatic step(input bit mis);
    bit exp_cyc, e;
    res_t r;
    a_out = 1'b0;
    y_out = mis;
    @(posedge clk);
    exp_cyc = (mcount == 17);
    if (mcount == 17) begin
      e = macc | mis;
      mtot += int'(e);
      mnum++;
      q.push_back('{e, mtot, mnum});
      macc = 1'b0;
    end else if (mcount >= 2 && mis) begin
      macc = 1'b1;
    end
    mcount = (mcount == 17) ? 0 : mcount + 1;
    #1;
    chk("count", count, mcount);
    chk("cycle_clk", cycle_clk, exp_cyc);
    chk_slices();
    if (cycle_clk) begin
      if (q.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        r = q.pop_front();
        chk("tc_error", tc_error, r.tc);
        chk("total_error", total_error, r.tot);
        chk("num_cases", num_cases, r.num);
      end
    end
  endtask

  // Run n cycles; a mismatch is presented only when the pre-edge count equals tgt.
  task automatic run(input int n, input int tgt);
    for (int i = 0; i < n; i++) step(mcount == tgt);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    a_out = 1'b0;
    y_out = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_cycle_clk", cycle_clk, 0);
    chk("rst_tc_error", tc_error, 0);
    chk("rst_total_error", total_error, 0);
    chk("rst_num_cases", num_cases, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_count", count, 0);
    reset = 1'b1;
    mcount = 0; macc = 1'b0; mtot = 0; mnum = 0;
    q.delete();
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) a[k*8 +: 8] = 8'(k);
    y = 16'hA5C3;
    reset = 1'b0;
    a_out = 1'b0;
    y_out = 1'b0;
    #1;
    do_reset();
    chk_slices();

    // Three clean blocks.
    run(54, -1);
    chk("clean_num", num_cases, 3);
    chk("clean_tot", total_error, 0);
    chk("clean_tc", tc_error, 0);

    // Mismatch during the uncompared pipeline-tail cycle is ignored.
    run(18, 1);
    chk("cnt1_tc", tc_error, 0);
    chk("cnt1_tot", total_error, 0);

    // Mismatch on the wrap cycle itself is counted.
    run(18, 17);
    chk("cnt17_tc", tc_error, 1);
    chk("cnt17_tot", total_error, 1);
    chk("cnt17_num", num_cases, 5);

    // Error block followed by a clean block.
    do_reset();
    run(18, 5);
    chk("b1_tc", tc_error, 1);
    chk("b1_tot", total_error, 1);
    run(18, -1);
    chk("b2_tc", tc_error, 0);
    chk("b2_tot", total_error, 1);
    chk("b2_num", num_cases, 2);

    // Abort mid-block with a pending mismatch; it must not leak.
    run(9, 5);
    chk("pre_abort_count", count, 9);
    do_reset();
    chk("abort_tot", total_error, 0);
    chk("abort_num", num_cases, 0);
    run(18, -1);
    chk("post_abort_tc", tc_error, 0);
    chk("post_abort_num", num_cases, 1);
    chk("post_abort_tot", total_error, 0);

    chk("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
